// File: rtl/lognet_sched_pkg.sv
// Shared definitions for the LogicNets LUT layer scheduler.
//   state_e      : scheduler FSM states
//   SEL_W/CFG_AW/IDX_W : widths for the default 16-neuron, fan-in 4, 32-input layer
//   clog2_min1   : width helper that never returns zero
//   reset_entry  : power-on connectivity table contents (entry j -> input j mod NUM_INPUTS)
package lognet_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CFG_AW = 6;
    localparam int unsigned IDX_W  = 5;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned reset_entry(input int unsigned j, input int unsigned num_inputs);
        return j % num_inputs;
    endfunction

endpackage

// File: rtl/lut_fanin_gather.sv
// Combinational fan-in gather: picks the FANIN input elements that feed neuron n
// out of the captured frame and packs them into a ROM address.
//   frame_i : captured input vector, element i at [i*IN_W +: IN_W]
//   table_i : flattened connectivity table, entry n*FANIN+k at [(n*FANIN+k)*IDX_W +: IDX_W]
//   n_i     : neuron index
//   addr_o  : ROM address, slot k at [k*IN_W +: IN_W]
module lut_fanin_gather #(
    parameter int unsigned NUM_INPUTS  = 32,
    parameter int unsigned IN_W        = 2,
    parameter int unsigned FANIN       = 4,
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned SEL_W       = lognet_sched_pkg::SEL_W,
    parameter int unsigned IDX_W       = lognet_sched_pkg::IDX_W
) (
    input  logic [NUM_INPUTS*IN_W-1:0]          frame_i,
    input  logic [NUM_NEURONS*FANIN*IDX_W-1:0]  table_i,
    input  logic [SEL_W-1:0]                    n_i,
    output logic [FANIN*IN_W-1:0]               addr_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        addr_o = '0;
        idx    = '0;
        for (int unsigned k = 0; k < FANIN; k++) begin
            idx = table_i[(32'(n_i) * FANIN + k) * IDX_W +: IDX_W];
            // Indices past the last element (non power-of-two NUM_INPUTS) read as zero.
            if (32'(idx) < NUM_INPUTS) begin
                addr_o[k*IN_W +: IN_W] = frame_i[32'(idx) * IN_W +: IN_W];
            end
        end
    end

endmodule

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexes one shared LUT truth-table ROM across all neurons of a layer.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    : input vector handshake (accepted only in IDLE)
//   out_valid/out_ready/out_data : layer result handshake (held in DONE)
//   lut_req/lut_sel/lut_addr     : registered ROM read strobe, page and address
//   lut_rdata             : ROM data, valid LUT_LAT cycles after lut_req
//   cfg_we/cfg_addr/cfg_data     : connectivity table write port (IDLE only)
//   cfg_err               : one-cycle pulse when a table write is dropped
//   busy                  : state is not IDLE
//   frame_cnt             : completed output handshakes, wrapping
module lut_layer_scheduler
    import lognet_sched_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 32,
    parameter int unsigned IN_W        = 2,
    parameter int unsigned FANIN       = 4,
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned OUT_W       = 2,
    parameter int unsigned LUT_LAT     = 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [NUM_INPUTS*IN_W-1:0]                     in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [NUM_NEURONS*OUT_W-1:0]                   out_data,
    output logic                                           lut_req,
    output logic [clog2_min1(NUM_NEURONS)-1:0]             lut_sel,
    output logic [FANIN*IN_W-1:0]                          lut_addr,
    input  logic [OUT_W-1:0]                               lut_rdata,
    input  logic                                           cfg_we,
    input  logic [clog2_min1(NUM_NEURONS*FANIN)-1:0]       cfg_addr,
    input  logic [clog2_min1(NUM_INPUTS)-1:0]              cfg_data,
    output logic                                           cfg_err,
    output logic                                           busy,
    output logic [15:0]                                    frame_cnt
);

    localparam int unsigned SW      = clog2_min1(NUM_NEURONS);
    localparam int unsigned IW      = clog2_min1(NUM_INPUTS);
    localparam int unsigned ENTRIES = NUM_NEURONS * FANIN;
    localparam int unsigned AD_W    = FANIN * IN_W;

    state_e                           state_q, state_d;
    logic [SW-1:0]                    cnt_q, cnt_d;
    logic [NUM_INPUTS*IN_W-1:0]       frame_q;
    logic [ENTRIES-1:0][IW-1:0]       table_q;
    logic                             lut_req_q;
    logic [SW-1:0]                    lut_sel_q;
    logic [AD_W-1:0]                  lut_addr_q;
    logic [AD_W-1:0]                  gather_addr;
    logic [LUT_LAT-1:0]               pv_q;
    logic [LUT_LAT-1:0][SW-1:0]       pn_q;
    logic [NUM_NEURONS*OUT_W-1:0]     out_data_q;
    logic                             cfg_err_q;
    logic [15:0]                      frame_cnt_q;
    logic                             inflight;
    logic                             cfg_ok;

    lut_fanin_gather #(
        .NUM_INPUTS  (NUM_INPUTS),
        .IN_W        (IN_W),
        .FANIN       (FANIN),
        .NUM_NEURONS (NUM_NEURONS),
        .SEL_W       (SW),
        .IDX_W       (IW)
    ) u_gather (
        .frame_i (frame_q),
        .table_i (table_q),
        .n_i     (cnt_q),
        .addr_o  (gather_addr)
    );

    // Anything that will still land in out_data after this edge. The tail stage
    // is excluded: it is consumed on the same edge that moves DRAIN to DONE.
    always_comb begin
        inflight = lut_req_q;
        for (int unsigned i = 0; i + 1 < LUT_LAT; i++) begin
            inflight = inflight | pv_q[i];
        end
    end

    assign cfg_ok = cfg_we && (state_q == ST_IDLE) && (32'(cfg_addr) < ENTRIES);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(NUM_NEURONS - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (!inflight) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            frame_q     <= '0;
            for (int unsigned j = 0; j < ENTRIES; j++) begin
                table_q[j] <= IW'(reset_entry(j, NUM_INPUTS));
            end
            lut_req_q   <= 1'b0;
            lut_sel_q   <= '0;
            lut_addr_q  <= '0;
            pv_q        <= '0;
            pn_q        <= '0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && in_valid) begin
                frame_q <= in_data;
            end
            // A write in the capture cycle lands before the first gather reads the table.
            if (cfg_ok) begin
                table_q[cfg_addr] <= cfg_data;
            end
            cfg_err_q <= cfg_we && !cfg_ok;
            lut_req_q <= (state_q == ST_ISSUE);
            if (state_q == ST_ISSUE) begin
                lut_sel_q  <= cnt_q;
                lut_addr_q <= gather_addr;
            end
            // Response tracker: stage 0 follows the registered request, so the
            // tail lines up with lut_rdata exactly LUT_LAT cycles after lut_req.
            pv_q[0] <= lut_req_q;
            pn_q[0] <= lut_sel_q;
            for (int unsigned i = 1; i < LUT_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pn_q[i] <= pn_q[i-1];
            end
            if (pv_q[LUT_LAT-1]) begin
                out_data_q[32'(pn_q[LUT_LAT-1]) * OUT_W +: OUT_W] <= lut_rdata;
            end
            if (state_q == ST_DONE && out_ready) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;
    assign lut_req   = lut_req_q;
    assign lut_sel   = lut_sel_q;
    assign lut_addr  = lut_addr_q;
    assign cfg_err   = cfg_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/lut_layer_scheduler.md
Name: lut_layer_scheduler

Overview:
- Time-multiplexes one shared LUT-neuron truth-table ROM across all NUM_NEURONS neurons of a LogicNets layer.
- Captures one quantised input vector per frame and gathers each neuron's fan-in elements through a configurable connectivity table.
- Issues one ROM lookup per cycle and assembles the OUT_W-bit neuron outputs into a layer output vector.
- Sits between the previous layer's registered output and the next layer, with valid/ready handshakes on both sides.

Parameters:
- NUM_INPUTS, 32: elements in the input vector.
- IN_W, 2: bits per input element.
- FANIN, 4: inputs per neuron. ROM address width is FANIN*IN_W.
- NUM_NEURONS, 16: neurons in the layer.
- OUT_W, 2: bits per neuron output.
- LUT_LAT, 1: ROM read latency in cycles, minimum 1.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- in_valid, in, 1: input vector valid.
- in_ready, out, 1: input vector accepted.
- in_data, in, NUM_INPUTS*IN_W: input vector; element i is at [i*IN_W +: IN_W].
- out_valid, out, 1: layer result valid.
- out_ready, in, 1: downstream accept.
- out_data, out, NUM_NEURONS*OUT_W: neuron n output is at [n*OUT_W +: OUT_W].
- lut_req, out, 1: ROM read strobe.
- lut_sel, out, clog2(NUM_NEURONS): neuron (ROM page) select.
- lut_addr, out, FANIN*IN_W: ROM address; fan-in slot k is at [k*IN_W +: IN_W].
- lut_rdata, in, OUT_W: ROM data, valid exactly LUT_LAT cycles after lut_req.
- cfg_we, in, 1: connectivity table write.
- cfg_addr, in, clog2(NUM_NEURONS*FANIN): table entry index, n*FANIN+k.
- cfg_data, in, clog2(NUM_INPUTS): input element index.
- cfg_err, out, 1: one-cycle pulse when a write is dropped.
- busy, out, 1: high when state is not IDLE.
- frame_cnt, out, 16: number of completed output handshakes; wraps at 0xFFFF to 0.

Behaviour:
- Reset values:
  - State IDLE.
  - in_ready=1, out_valid=0, out_data=0.
  - lut_req=0, lut_sel=0, lut_addr=0.
  - cfg_err=0, busy=0, frame_cnt=0.
  - Table entry j = j mod NUM_INPUTS.
  - Response tracking pipeline cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, register in_data into the frame buffer, clear the neuron counter and enter ISSUE.
- ISSUE:
  - Each cycle, for counter n (0..NUM_NEURONS-1), drive lut_req=1 and lut_sel=n.
  - lut_addr slot k = frame_buf element table[n*FANIN+k].
  - These outputs are registered, so they appear on the cycle after the counter value is set.
  - After n=NUM_NEURONS-1 is issued, enter DRAIN.
- Response tracking:
  - A LUT_LAT-deep shift register carries {valid, n}.
  - When its tail is valid, lut_rdata is written into out_data slot n.
- DRAIN: wait until the tracking pipe is empty, then enter DONE.
- DONE:
  - out_valid=1; out_data is held stable.
  - On out_ready: out_valid=0 the next cycle, frame_cnt increments, return to IDLE.
  - in_ready is 0 in DONE; there is no overlap between frames.
- Latency with LUT_LAT=1:
  - Accept edge at cycle 0; lut_req high during cycles 1..NUM_NEURONS.
  - out_valid rises in cycle NUM_NEURONS+2.
  - In general, out_valid is asserted NUM_NEURONS+LUT_LAT+1 cycles after the accept edge.
- out_ready held high before DONE has no effect.
- Configuration:
  - A write is applied only when the state is IDLE.
  - Otherwise it is dropped and cfg_err pulses for one cycle.
  - cfg_addr >= NUM_NEURONS*FANIN is dropped and cfg_err pulses for one cycle.
- cfg_we and in_valid in the same IDLE cycle: the write commits on the same edge as the capture, and the frame uses the new entry.
- cfg_data >= NUM_INPUTS: stored truncated to clog2(NUM_INPUTS) bits; no error is raised.
- Reset mid-operation:
  - All state returns to reset values immediately, including the connectivity table.
  - In-flight lut_rdata is ignored.
  - No partial out_valid is produced.
- lut_rdata is sampled only when a tracking tail is valid; it is don't-care otherwise.

Decomposition:
- Shared package lognet_sched_pkg holds:
  - The state enum (IDLE/ISSUE/DRAIN/DONE).
  - Width helper constants: SEL_W, CFG_AW, IDX_W.
  - A function computing the reset table value.
- One sub-module, lut_fanin_gather: purely combinational. Given the frame buffer, the table row of neuron n and n, it produces lut_addr.
- The scheduler instantiates lut_fanin_gather and owns all registers.

Test Plan:
- Reset-table frame:
  - Setup: defaults; stub ROM returns 2'b01 when addr==8'b00110010 and sel==0, else 2'b00.
  - Stimulus: table writes entry0=2, entry1=0, entry2=3, entry3=0; in_data element0=2'b00, element2=2'b10, element3=2'b11 (address {e0,e3,e0,e2} = 8'b00110010).
  - Response: out_data=32'h0000_0001; out_valid in cycle 18 after accept.
- Handshake backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE.
  - Response: out_valid and out_data stable; in_ready=0; frame_cnt unchanged; it increments by 1 on the cycle after out_ready=1.
- Config while busy:
  - Stimulus: cfg_we during ISSUE at cfg_addr=5.
  - Response: cfg_err pulses for 1 cycle; entry 5 unchanged (verified by the next frame's lut_addr).
- Simultaneous cfg and in_valid in IDLE:
  - Stimulus: cfg_addr=0, cfg_data=7, together with in_valid.
  - Response: the first lookup's lut_addr slot0 equals element 7.
- Reset mid-ISSUE at n=8:
  - Response: out_valid=0, busy=0, in_ready=1, table back to j mod 32.
  - Follow-up: the next frame's result matches the golden model.
- LUT_LAT=3 build:
  - Response: out_valid at cycle NUM_NEURONS+4 after accept.
  - Each slot n holds the ROM response to lut_sel=n (stub returns n[1:0]).
